// File: rtl/seq_stream_pkg.sv
// Shared FSM state type and default counter width for the data streamer.
// ST_GAP only exists when SEQ_STREAM_GAP_EN is defined.
package seq_stream_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_SEND,
`ifdef SEQ_STREAM_GAP_EN
        ST_NEXT,
        ST_GAP
`else
        ST_NEXT
`endif
    } state_t;

endpackage

// File: rtl/seq_data_streamer_if.sv
// Valid/ready stream bundle carrying one data word plus a frame-last flag.
// The streamer drives it through the master modport.
interface seq_data_streamer_if #(
    parameter int DSIZE = 32
);
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/seq_data_streamer.sv
// Plays total_length words from an upstream memory model onto a stream,
// framing with m_last. Optional inter-word gap under SEQ_STREAM_GAP_EN.
module seq_data_streamer
    import seq_stream_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    total_length,
    input  logic [CNT_W-1:0]    frame_len,
`ifdef SEQ_STREAM_GAP_EN
    input  logic [15:0]         gap_cycles,
`endif
    output logic                src_load,
    output logic                src_next,
    input  logic [DSIZE-1:0]    src_data,
    seq_data_streamer_if.master m,
    output logic                busy,
    output logic                done
);

    state_t           state_q, state_d;
    logic [DSIZE-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             src_load_q, src_load_d;
    logic             src_next_q, src_next_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`ifdef SEQ_STREAM_GAP_EN
    logic [15:0]      gap_q, gap_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;
`endif

    logic final_w;
    logic last_w;
    logic hs_w;

    // total_q >= 1 whenever these are evaluated, so no underflow
    assign final_w = (word_cnt_q == total_q - CNT_W'(1));
    assign last_w  = final_w ||
                     ((frame_q != '0) &&
                      (frame_cnt_q == frame_q - CNT_W'(1)));
    assign hs_w    = m_valid_q && m.m_ready;

    always_comb begin
        state_d     = state_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        src_load_d  = 1'b0;
        src_next_d  = 1'b0;
        done_d      = 1'b0;
        total_d     = total_q;
        frame_d     = frame_q;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
`ifdef SEQ_STREAM_GAP_EN
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (total_length != '0) begin
                        total_d     = total_length;
                        frame_d     = frame_len;
                        word_cnt_d  = '0;
                        frame_cnt_d = '0;
`ifdef SEQ_STREAM_GAP_EN
                        gap_d       = gap_cycles;
                        gap_cnt_d   = '0;
`endif
                        src_load_d  = 1'b1;
                        state_d     = ST_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                m_data_d  = src_data;
                m_valid_d = 1'b1;
                m_last_d  = last_w;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (hs_w) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (final_w) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        word_cnt_d  = word_cnt_q + CNT_W'(1);
                        frame_cnt_d = m_last_q ? '0
                                    : frame_cnt_q + CNT_W'(1);
`ifdef SEQ_STREAM_GAP_EN
                        if (gap_q != '0) begin
                            gap_cnt_d = gap_q - 16'd1;
                            state_d   = ST_GAP;
                        end else begin
                            src_next_d = 1'b1;
                            state_d    = ST_NEXT;
                        end
`else
                        src_next_d = 1'b1;
                        state_d    = ST_NEXT;
`endif
                    end
                end
            end
            ST_NEXT: begin
                state_d = ST_FETCH;
            end
`ifdef SEQ_STREAM_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    src_next_d = 1'b1;
                    state_d    = ST_NEXT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            src_load_q  <= 1'b0;
            src_next_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            total_q     <= '0;
            frame_q     <= '0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
`ifdef SEQ_STREAM_GAP_EN
            gap_q       <= '0;
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            src_load_q  <= src_load_d;
            src_next_q  <= src_next_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            total_q     <= total_d;
            frame_q     <= frame_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef SEQ_STREAM_GAP_EN
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    assign m.m_data  = m_data_q;
    assign m.m_valid = m_valid_q;
    assign m.m_last  = m_last_q;
    assign src_load  = src_load_q;
    assign src_next  = src_next_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_data_streamer.sv
// Directed bench for seq_data_streamer with an upstream memory model
// and a negedge stream monitor.
module tb_seq_data_streamer;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] total_length = '0;
    logic [CW-1:0] frame_len = '0;
`ifdef SEQ_STREAM_GAP_EN
    logic [15:0]   gap_cycles = '0;
`endif
    logic          src_load;
    logic          src_next;
    logic [DW-1:0] src_data;
    logic          busy;
    logic          done;

    seq_data_streamer_if #(.DSIZE(DW)) sif ();

    seq_data_streamer #(.DSIZE(DW), .CNT_W(CW)) dut (
        .clock        (clock),
        .rst          (rst),
        .start        (start),
        .total_length (total_length),
        .frame_len    (frame_len),
`ifdef SEQ_STREAM_GAP_EN
        .gap_cycles   (gap_cycles),
`endif
        .src_load     (src_load),
        .src_next     (src_next),
        .src_data     (src_data),
        .m            (sif),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // upstream memory model
    logic [DW-1:0] mem [8];
    int ptr = 0;
    always @(posedge clock) begin
        if (src_load) ptr <= 0;
        else if (src_next) ptr <= ptr + 1;
    end
    assign src_data = mem[ptr & 7];

    // stream monitor
    logic [DW-1:0] bd_q [$];
    logic          bl_q [$];
    int            bc_q [$];
    int            rise_q [$];
    int            n_next = 0;
    int            n_load = 0;
    logic          pv = 1'b0;

    always @(negedge clock) begin
        if (sif.m_valid && sif.m_ready) begin
            bd_q.push_back(sif.m_data);
            bl_q.push_back(sif.m_last);
            bc_q.push_back(cyc);
        end
        if (sif.m_valid && !pv) rise_q.push_back(cyc);
        pv = sif.m_valid;
        if (src_next) n_next = n_next + 1;
        if (src_load) n_load = n_load + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic start_seq(input int tot, input int fl);
        total_length = CW'(tot);
        frame_len    = CW'(fl);
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int k = 0; k < budget && dc < 0; k++) begin
            step();
            if (done) begin
                dc = cyc;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
        chk("done_seen", 64'(dc >= 0), 64'd1);
    endtask

    int b0, l0, x0, r0, dc, snap;
    logic [5:0] lv;
    logic       found;

    initial begin
        sif.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // reset state
        step();
        step();
        chk("rst_valid", 64'(sif.m_valid), 64'd0);
        chk("rst_last", 64'(sif.m_last), 64'd0);
        chk("rst_data", 64'(sif.m_data), 64'd0);
        chk("rst_load", 64'(src_load), 64'd0);
        chk("rst_next", 64'(src_next), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        step();

        // four words, single frame, ready held high
        for (int i = 0; i < 4; i++) mem[i] = DW'(32'hA0 + i);
        sif.m_ready = 1'b1;
        b0 = bd_q.size(); l0 = n_load; x0 = n_next; r0 = rise_q.size();
        start_seq(4, 0);
        chk("t1_load_c1", 64'(src_load), 64'd1);
        chk("t1_busy_c1", 64'(busy), 64'd1);
        step();
        chk("t1_load_c2", 64'(src_load), 64'd0);
        chk("t1_valid_c2", 64'(sif.m_valid), 64'd0);
        step();
        chk("t1_valid_c3", 64'(sif.m_valid), 64'd1);
        chk("t1_data_c3", 64'(sif.m_data), 64'hA0);
        wait_done(40, dc);
        chk("t1_beats", 64'(bd_q.size() - b0), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("t1_data", 64'(bd_q[b0 + i]), 64'(32'hA0 + i));
        lv = '0;
        for (int i = 0; i < 4; i++) lv[i] = bl_q[b0 + i];
        chk("t1_lasts", 64'(lv), 64'b001000);
        chk("t1_next_cnt", 64'(n_next - x0), 64'd3);
        chk("t1_load_cnt", 64'(n_load - l0), 64'd1);
        chk("t1_done_lat", 64'(dc - bc_q[b0 + 3]), 64'd1);
        chk("t1_spacing", 64'(rise_q[r0 + 1] - rise_q[r0]), 64'd3);
        step();
        chk("t1_done_pulse", 64'(done), 64'd0);

        // six words in frames of two, with an ignored start mid-run
        for (int i = 0; i < 6; i++) mem[i] = DW'(32'hB0 + i);
        b0 = bd_q.size();
        start_seq(6, 2);
        step();
        step();
        step();
        start_seq(2, 0);
        wait_done(60, dc);
        chk("t2_beats", 64'(bd_q.size() - b0), 64'd6);
        lv = '0;
        for (int i = 0; i < 6; i++) lv[i] = bl_q[b0 + i];
        chk("t2_lasts", 64'(lv), 64'b101010);
        chk("t2_final_data", 64'(bd_q[b0 + 5]), 64'hB5);

        // backpressure on the second beat
        for (int i = 0; i < 4; i++) mem[i] = DW'(32'hD0 + i);
        sif.m_ready = 1'b0;
        b0 = bd_q.size();
        start_seq(4, 0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            found = sif.m_valid;
        end
        chk("t3_first_valid", 64'(found), 64'd1);
        sif.m_ready = 1'b1;
        step();
        sif.m_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (sif.m_valid) found = 1'b1;
            else step();
        end
        chk("t3_second_valid", 64'(found), 64'd1);
        snap = n_next;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(sif.m_valid), 64'd1);
            chk("t3_hold_data", 64'(sif.m_data), 64'hD1);
            step();
        end
        chk("t3_no_next", 64'(n_next - snap), 64'd0);
        sif.m_ready = 1'b1;
        wait_done(40, dc);
        chk("t3_beats", 64'(bd_q.size() - b0), 64'd4);
        chk("t3_beat2", 64'(bd_q[b0 + 1]), 64'hD1);
        chk("t3_beat4", 64'(bd_q[b0 + 3]), 64'hD3);

        // zero-length request
        l0 = n_load;
        start_seq(0, 0);
        chk("t4_done_c1", 64'(done), 64'd1);
        chk("t4_busy_c1", 64'(busy), 64'd0);
        chk("t4_load_c1", 64'(src_load), 64'd0);
        step();
        chk("t4_done_c2", 64'(done), 64'd0);
        chk("t4_busy_c2", 64'(busy), 64'd0);
        chk("t4_load_cnt", 64'(n_load - l0), 64'd0);

        // reset during the third of eight beats
        for (int i = 0; i < 8; i++) mem[i] = DW'(32'hC0 + i);
        b0 = bd_q.size();
        start_seq(8, 0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = sif.m_valid && (bd_q.size() - b0 == 2);
        end
        chk("t5_beat3_seen", 64'(found), 64'd1);
        chk("t5_beat3_data", 64'(sif.m_data), 64'hC2);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(sif.m_valid), 64'd0);
        chk("t5_rst_last", 64'(sif.m_last), 64'd0);
        chk("t5_rst_data", 64'(sif.m_data), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        chk("t5_rst_next", 64'(src_next), 64'd0);
        step();
        chk("t5_rst_hold_done", 64'(done), 64'd0);
        rst = 1'b0;
        step();
        b0 = bd_q.size();
        start_seq(8, 0);
        chk("t5_reload", 64'(src_load), 64'd1);
        step();
        step();
        chk("t5_replay_data", 64'(sif.m_data), 64'hC0);
        wait_done(80, dc);
        chk("t5_beats", 64'(bd_q.size() - b0), 64'd8);
        chk("t5_final_data", 64'(bd_q[b0 + 7]), 64'hC7);
        chk("t5_final_last", 64'(bl_q[b0 + 7]), 64'd1);

`ifdef SEQ_STREAM_GAP_EN
        // inter-word gap of three cycles
        for (int i = 0; i < 4; i++) mem[i] = DW'(32'hE0 + i);
        gap_cycles = 16'd3;
        r0 = rise_q.size();
        start_seq(4, 0);
        wait_done(80, dc);
        chk("t6_gap_1", 64'(rise_q[r0 + 1] - rise_q[r0]), 64'd6);
        chk("t6_gap_2", 64'(rise_q[r0 + 2] - rise_q[r0 + 1]), 64'd6);
        chk("t6_gap_3", 64'(rise_q[r0 + 3] - rise_q[r0 + 2]), 64'd6);
        gap_cycles = 16'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
